// File: rtl/key_pkg.sv
// Shared types and default timing constants for the key_interface block.
package key_pkg;

    // Bit 1 of the encoding is the debounced level (HELD and RELEASE_WAIT both read as held).
    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        HELD         = 2'b10,
        RELEASE_WAIT = 2'b11
    } key_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: inverting two-flop synchronizer, debounce FSM with sample counter,
// registered press/release pulses. Autorepeat is built only with KEY_AUTOREPEAT_EN.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_key_n,
    output logic [1:0] o_state,
    output logic       o_press,
    output logic       o_release
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("key_debounce: timing parameters out of range");
    end

    logic             r_sync1;
    logic             r_sync2;
    key_state_t       r_state;
    key_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_accept_press;
    logic             w_accept_release;
    logic             w_rep_hit;
    logic             r_press;
    logic             r_release;

    // Synchronizer carries "pressed" (1) so its reset value means released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= ~i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_accept_press   = 1'b0;
        w_accept_release = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_sync2) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (!r_sync2) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt    = HELD;
                    w_cnt_nxt      = '0;
                    w_accept_press = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!r_sync2) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (r_sync2) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt      = IDLE;
                    w_cnt_nxt        = '0;
                    w_accept_release = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int REP_W = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_rep_armed;
    logic             w_rep_stay;

    // Counts only while HELD persists across an edge; any exit (incl. a release bounce) restarts it.
    assign w_rep_stay = (r_state == HELD) && (w_state_nxt == HELD);
    assign w_rep_hit  = w_rep_stay && (r_rep_cnt == (r_rep_armed ? REP_NEXT : REP_FIRST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (!w_rep_stay) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (w_rep_hit) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b1;
        end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end
`else
    assign w_rep_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_accept_press | w_rep_hit;
            r_release <= w_accept_release;
        end
    end

    assign o_state   = r_state;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/key_interface.sv
// Pushbutton debounce and switch synchronization front end.
// Optional autorepeat on held keys is enabled by defining KEY_AUTOREPEAT_EN.
module key_interface
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int NUM_SW          = 10,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] KEY,
    input  logic [NUM_SW-1:0]   SW,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_SW-1:0]   sw_sync
);

    logic [NUM_SW-1:0] r_sw_meta;
    logic [NUM_SW-1:0] r_sw_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= SW;
            r_sw_sync <= r_sw_meta;
        end
    end

    assign sw_sync = r_sw_sync;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        logic [1:0] w_state;

        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_key_debounce (
            .clk       (clk),
            .rst       (rst),
            .i_key_n   (KEY[g]),
            .o_state   (w_state),
            .o_press   (key_press[g]),
            .o_release (key_release[g])
        );

        // Reduces to state bit 1, so the level comes straight off a flop.
        assign key_level[g] = (w_state == HELD) || (w_state == RELEASE_WAIT);
    end

endmodule

// File: tb/tb_key_interface.sv
// Bench for key_interface with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Expected press/release pulses are queued as {cycle, kind, key} when stimulus is driven.
module tb_key_interface;

    localparam int NK = 4;
    localparam int NS = 10;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif
    localparam logic [3:0] EV_PRESS   = 4'd1;
    localparam logic [3:0] EV_RELEASE = 4'd2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] KEY;
    logic [NS-1:0] SW;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NS-1:0] sw_sync;

    int          cyc = 0;
    int          n_total = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    int          c, d, r, r2, k, n;
    logic [NS-1:0] sw_prev, sw_new;

    key_interface #(
        .NUM_KEYS        (NK),
        .NUM_SW          (NS),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .KEY         (KEY),
        .SW          (SW),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .sw_sync     (sw_sync)
    );

    // clock / cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic push_exp(input logic [3:0] kind, input int key, input int at);
        logic [31:0] v;
        int          i;
        v = {at[23:0], kind, 4'(key)};
        i = 0;
        while (i < exp_q.size() && exp_q[i] <= v) i++;
        exp_q.insert(i, v);
    endtask

    // Autorepeat pulses for a HELD stretch entered at edge h and still HELD at edge last.
    task automatic push_repeats(input int key, input int h, input int last);
        int t;
        t = h + RD;
        while (REP_ON && t <= last) begin
            push_exp(EV_PRESS, key, t);
            t += RP;
        end
    endtask

    // Key driven low at negedge c for n_low edges, then released for good.
    task automatic expect_hold(input int key, input int c0, input int n_low);
        if (n_low >= DB) begin
            push_exp(EV_PRESS, key, c0 + DB + 2);
            push_repeats(key, c0 + DB + 2, c0 + n_low + 2);
            push_exp(EV_RELEASE, key, c0 + n_low + DB + 2);
        end
    endtask

    task automatic match_evt(input logic [3:0] kind, input int key);
        logic [31:0] obs;
        logic [31:0] exp;
        obs = {cyc[23:0], kind, 4'(key)};
        if (exp_q.size() == 0) exp = 32'h0;
        else exp = exp_q.pop_front();
        check("event", obs, exp);
    endtask

    // monitor: samples 1 time unit after each active edge
    always begin
        @(posedge clk);
        #1;
        check("press_release_excl", 32'(key_press & key_release), 32'h0);
        for (int i = 0; i < NK; i++) if (key_press[i]) match_evt(EV_PRESS, i);
        for (int i = 0; i < NK; i++) if (key_release[i]) match_evt(EV_RELEASE, i);
    end

    initial begin
        rst = 1'b0;
        KEY = 4'b1110;
        SW  = '1;
        tick(3);
        check("rst_level", 32'(key_level), 32'h0);
        check("rst_press", 32'(key_press), 32'h0);
        check("rst_release", 32'(key_release), 32'h0);
        check("rst_sw", 32'(sw_sync), 32'h0);

        // key 0 held through reset, then held 28 cycles past HELD entry
        rst = 1'b1;
        c = cyc;
        push_exp(EV_PRESS, 0, c + DB + 2);
        tick(1); check("sw_lag1", 32'(sw_sync), 32'h0);
        tick(1); check("sw_lag2", 32'(sw_sync), 32'h3FF);
        tick(3); check("k0_pre", 32'(key_level[0]), 32'h0);
        tick(1); check("k0_held", 32'(key_level[0]), 32'h1);
        tick(28);
        r = cyc;
        KEY[0] = 1'b1;
        push_repeats(0, c + DB + 2, r + 2);
        push_exp(EV_RELEASE, 0, r + DB + 2);
        tick(DB + 1); check("k0_rel_pre", 32'(key_level[0]), 32'h1);
        tick(1); check("k0_rel", 32'(key_level[0]), 32'h0);
        tick(4);

        // key 1: 3-sample glitch rejected, 4-sample press accepted
        KEY[1] = 1'b0;
        tick(3);
        KEY[1] = 1'b1;
        tick(3); check("k1_glitch_a", 32'(key_level[1]), 32'h0);
        tick(5); check("k1_glitch_b", 32'(key_level[1]), 32'h0);
        c = cyc;
        KEY[1] = 1'b0;
        expect_hold(1, c, DB);
        tick(DB);
        KEY[1] = 1'b1;
        tick(2); check("k1_min_press", 32'(key_level[1]), 32'h1);
        tick(10);

        // key 2: held, 3-sample release bounce, then real release
        c = cyc;
        KEY[2] = 1'b0;
        push_exp(EV_PRESS, 2, c + DB + 2);
        tick(20);
        r = cyc;
        KEY[2] = 1'b1;
        push_repeats(2, c + DB + 2, r + 2);
        tick(3);
        KEY[2] = 1'b0;
        tick(3); check("k2_bounce", 32'(key_level[2]), 32'h1);
        tick(7);
        r2 = cyc;
        KEY[2] = 1'b1;
        push_repeats(2, r + 6, r2 + 2);
        push_exp(EV_RELEASE, 2, r2 + DB + 2);
        tick(DB + 1); check("k2_rel_pre", 32'(key_level[2]), 32'h1);
        tick(1); check("k2_rel", 32'(key_level[2]), 32'h0);
        tick(4);

        // key 3: reset while HELD, key stays down through and after reset
        c = cyc;
        KEY[3] = 1'b0;
        push_exp(EV_PRESS, 3, c + DB + 2);
        tick(9);
        push_repeats(3, c + DB + 2, cyc);
        rst = 1'b0;
        #1;
        check("k3_rst_level", 32'(key_level), 32'h0);
        check("k3_rst_press", 32'(key_press), 32'h0);
        check("k3_rst_release", 32'(key_release), 32'h0);
        tick(1);
        rst = 1'b1;
        d = cyc;
        push_exp(EV_PRESS, 3, d + DB + 2);
        tick(DB + 1); check("k3_re_pre", 32'(key_level[3]), 32'h0);
        tick(1); check("k3_re_held", 32'(key_level[3]), 32'h1);
        tick(6);
        r = cyc;
        KEY[3] = 1'b1;
        push_repeats(3, d + DB + 2, r + 2);
        push_exp(EV_RELEASE, 3, r + DB + 2);
        tick(10);

        // key 3: reset one sample before acceptance discards the partial debounce
        KEY[3] = 1'b0;
        tick(DB + 1);
        rst = 1'b0;
        #1;
        check("k3_abort", 32'(key_level[3]), 32'h0);
        tick(1);
        rst = 1'b1;
        d = cyc;
        push_exp(EV_PRESS, 3, d + DB + 2);
        tick(DB + 1); check("k3_abort_pre", 32'(key_level[3]), 32'h0);
        tick(1); check("k3_abort_held", 32'(key_level[3]), 32'h1);
        tick(2);
        r = cyc;
        KEY[3] = 1'b1;
        push_repeats(3, d + DB + 2, r + 2);
        push_exp(EV_RELEASE, 3, r + DB + 2);
        tick(10);

        // switches: exactly two edges of lag, keys untouched
        sw_prev = '1;
        for (int i = 0; i < 3; i++) begin
            sw_new = (i == 0) ? 10'h2A5 : 10'($urandom_range(0, 1023));
            SW = sw_new;
            tick(1); check("sw_lag", 32'(sw_sync), 32'(sw_prev));
            tick(1); check("sw_sync", 32'(sw_sync), 32'(sw_new));
            check("sw_keys", 32'(key_level), 32'h0);
            sw_prev = sw_new;
        end

        // all keys pressed together
        c = cyc;
        KEY = '0;
        for (int i = 0; i < NK; i++) expect_hold(i, c, 8);
        tick(DB + 2); check("all_held", 32'(key_level), 32'hF);
        tick(2);
        KEY = '1;
        tick(12);

        // random key / press length, including sub-threshold glitches
        for (int i = 0; i < 6; i++) begin
            k = $urandom_range(0, NK - 1);
            n = $urandom_range(2, 9);
            c = cyc;
            KEY[k] = 1'b0;
            expect_hold(k, c, n);
            tick(n);
            KEY[k] = 1'b1;
            tick(12);
        end

        tick(4);
        check("leftover_events", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/key_interface.md
KEY_INTERFACE -- requirements
Module: key_interface

Interface
REQ-001 The block SHALL have a single clock `clk`; reset `rst` SHALL be asynchronous and active-low.
REQ-002 Parameters, one per line:
- NUM_KEYS, 4, number of pushbuttons.
- NUM_SW, 10, number of slide switches.
- DEBOUNCE_CYCLES, 500000, stable samples required; must be >= 2.
- REPEAT_DELAY, 25000000, cycles held before the first autorepeat.
- REPEAT_PERIOD, 5000000, cycles between autorepeats.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- KEY  in  NUM_KEYS  raw pushbuttons; 0 = pressed; asynchronous.
- SW  in  NUM_SW  raw switches; asynchronous.
- key_level  out  NUM_KEYS  debounced state; 1 = held.
- key_press  out  NUM_KEYS  one-cycle pulse per accepted press or repeat.
- key_release  out  NUM_KEYS  one-cycle pulse per accepted release.
- sw_sync  out  NUM_SW  synchronized switch levels.

Function
REQ-004 Each KEY bit SHALL be inverted, then passed through a two-flop synchronizer; each SW bit SHALL pass through a two-flop synchronizer.
REQ-005 The sw_sync output SHALL lag SW by exactly 2 clk edges, with no debounce.
REQ-006 Each key SHALL run an independent FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, plus a counter of width $clog2(DEBOUNCE_CYCLES).
REQ-007 IDLE SHALL behave as follows:
- synchronized pressed = 1 -> PRESS_WAIT, count = 1.
- otherwise stay in IDLE.
REQ-008 PRESS_WAIT SHALL behave as follows:
- sample 0 -> IDLE, count = 0.
- sample 1 with count == DEBOUNCE_CYCLES-1 -> HELD.
- otherwise count += 1.
REQ-009 On entry to HELD, key_level SHALL go to 1 and key_press SHALL assert for exactly that one cycle.
REQ-010 Press latency SHALL be: key_level and key_press visible after the (DEBOUNCE_CYCLES+2)th consecutive edge at which KEY[i] is sampled low.
REQ-011 HELD, RELEASE_WAIT and the key_release pulse SHALL mirror REQ-007..REQ-010 with the polarity inverted:
- a release-side sample of 1 during RELEASE_WAIT returns the FSM to HELD with no pulse.
- entry to IDLE clears key_level and pulses key_release for one cycle.
REQ-012 Any glitch shorter than DEBOUNCE_CYCLES samples SHALL produce no change on key_level, key_press or key_release.
REQ-013 key_press and key_release SHALL never assert in the same cycle for the same key; keys SHALL not interact, and simultaneous presses on several keys SHALL pulse in the same cycle.
REQ-014 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-015 When rst is low, the block SHALL asynchronously clear the following:
- all FSMs to IDLE and all counters to 0.
- synchronizer flops to "released" (key) and 0 (switch).
- key_level, key_press, key_release and sw_sync to 0.
REQ-016 After rst deasserts, a key held throughout reset SHALL be debounced afresh and SHALL produce exactly one key_press per REQ-010.
REQ-017 Reset asserted mid-debounce SHALL discard the partial count.

Configuration
REQ-018 With KEY_AUTOREPEAT_EN defined, a key remaining in HELD SHALL re-pulse key_press:
- first repeat REPEAT_DELAY cycles after HELD entry.
- subsequent repeats every REPEAT_PERIOD cycles.
- the repeat counter clears on leaving HELD and on reset.
REQ-019 Without KEY_AUTOREPEAT_EN, no repeat counter SHALL be synthesized, and exactly one key_press SHALL be emitted per accepted press.

Structure
REQ-020 A shared package key_pkg SHALL hold the following:
- the FSM state enum (key_state_t: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT).
- default constants for DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD.
REQ-021 Per-key logic SHALL live in a sub-module key_debounce (synchronizer, FSM, counters), instantiated NUM_KEYS times by a generate loop; switch synchronizers stay in the top level.

Verification (bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-022 KEY[0] driven low and held -> key_level[0]=1 and key_press[0] pulse after 6th edge; no further pulses (macro off).
REQ-023 KEY[1] low for 3 edges then high -> key_level[1], key_press[1] and key_release[1] stay 0 throughout.
REQ-024 KEY[2] pressed then released after 20 cycles -> key_release[2] single pulse after 6th edge of high; key_level[2]=0.
REQ-025 KEY[3] held, rst pulsed low mid-HELD -> outputs 0 immediately; after release of rst, new key_press[3] after 6 edges.
REQ-026 SW=10'h2A5 applied -> sw_sync=10'h2A5 after 2 edges, KEY outputs unaffected.
REQ-027 KEY_AUTOREPEAT_EN, KEY[0] held 30 cycles after HELD -> key_press[0] pulses at HELD+0, +10, +13, +16, ..., +28.
